// File: rtl/trng_seq_ctrl_if.sv
// Bundle of the sequencer's control, entropy and consumer-side signals.
// The slave modport is the sequencer's view; the master modport is the surrounding logic's view.
interface trng_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             i_start;
   logic             i_rand;
   logic             i_rand_valid;
   logic             i_ready;
   logic             i_clr_fault;
   logic             o_en_sim;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             o_busy;
   logic             o_fault;
   logic [2:0]       o_dbg_state;

   modport slave (
      input  i_start, i_rand, i_rand_valid, i_ready, i_clr_fault,
      output o_en_sim, o_data, o_valid, o_busy, o_fault, o_dbg_state
   );

   modport master (
      output i_start, i_rand, i_rand_valid, i_ready, i_clr_fault,
      input  o_en_sim, o_data, o_valid, o_busy, o_fault, o_dbg_state
   );
endinterface

// File: rtl/trng_seq_ctrl.sv
// TRNG request/response sequencer: warm-up, bit collection with repetition and
// starvation health tests, and a valid/ready word handoff with a sticky fault.
module trng_seq_ctrl #(
   parameter int WIDTH         = 8,
   parameter int WARMUP_CYCLES = 16,
   parameter int REP_LIMIT     = 8,
   parameter int TIMEOUT       = 255
) (
   input  logic            i_clk,
   input  logic            i_rst,
   trng_seq_ctrl_if.slave  bus
);
   localparam int BCW = $clog2(WIDTH + 1);
   localparam int WCW = $clog2(WARMUP_CYCLES + 1);
   localparam int RCW = $clog2(REP_LIMIT + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WARMUP  = 3'd1;
   localparam logic [2:0] S_COLLECT = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_FAULT   = 3'd4;

   // Handshake: o_data is a word only while o_valid=1; it transfers on a rising
   // edge where o_valid=1 and i_ready=1, and o_data stays fixed until then.

   logic [2:0]       r_state;
   logic [WCW-1:0]   r_warm_cnt;
   logic [BCW-1:0]   r_bit_cnt;
   logic [RCW-1:0]   r_run_cnt;
   logic [TCW-1:0]   r_to_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_data;
   logic             r_en_sim;
   logic             r_valid;
   logic             r_busy;
   logic             r_fault;

   logic [2:0]       w_state_nxt;
   logic [WCW-1:0]   w_warm_nxt;
   logic [BCW-1:0]   w_bit_nxt;
   logic [RCW-1:0]   w_run_nxt;
   logic [TCW-1:0]   w_to_nxt;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [WIDTH-1:0] w_data_nxt;
   logic [WIDTH-1:0] w_shift_cand;
   logic [BCW-1:0]   w_bit_inc;
   logic [RCW-1:0]   w_run_cand;
   logic [TCW-1:0]   w_to_inc;
   logic             w_begin;

   assign w_shift_cand = {r_shift[WIDTH-2:0], bus.i_rand};
   assign w_bit_inc    = r_bit_cnt + BCW'(1);
   assign w_to_inc     = r_to_cnt + TCW'(1);

   // The run restarts at every word; r_shift[0] is the previously accepted bit.
   always_comb begin
      w_run_cand = RCW'(1);
      if ((r_bit_cnt != '0) && (bus.i_rand == r_shift[0])) begin
         w_run_cand = r_run_cnt + RCW'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_warm_nxt  = r_warm_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_run_nxt   = r_run_cnt;
      w_to_nxt    = r_to_cnt;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_begin     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_begin = 1'b1;
            end
         end
         S_WARMUP: begin
            if (r_warm_cnt == '0) begin
               w_state_nxt = S_COLLECT;
            end else begin
               w_warm_nxt = r_warm_cnt - WCW'(1);
            end
         end
         S_COLLECT: begin
            if (bus.i_rand_valid) begin
               w_shift_nxt = w_shift_cand;
               w_bit_nxt   = w_bit_inc;
               w_run_nxt   = w_run_cand;
               w_to_nxt    = '0;
               // A failed health test outranks a word completing on the same bit.
               if (w_run_cand == RCW'(REP_LIMIT)) begin
                  w_state_nxt = S_FAULT;
                  w_data_nxt  = '0;
               end else if (w_bit_inc == BCW'(WIDTH)) begin
                  w_state_nxt = S_HOLD;
                  w_data_nxt  = w_shift_cand;
               end
            end else begin
               w_to_nxt = w_to_inc;
               if (w_to_inc == TCW'(TIMEOUT)) begin
                  w_state_nxt = S_FAULT;
                  w_data_nxt  = '0;
               end
            end
         end
         S_HOLD: begin
            if (bus.i_ready) begin
               if (bus.i_start) begin
                  w_begin = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_FAULT: begin
            if (bus.i_clr_fault) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_begin) begin
         w_state_nxt = S_WARMUP;
         w_warm_nxt  = WCW'(WARMUP_CYCLES - 1);
         w_bit_nxt   = '0;
         w_run_nxt   = '0;
         w_to_nxt    = '0;
         w_shift_nxt = '0;
      end
   end

   // Outputs are registered from the next state so they align with the state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_warm_cnt <= '0;
         r_bit_cnt  <= '0;
         r_run_cnt  <= '0;
         r_to_cnt   <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_en_sim   <= 1'b0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_warm_cnt <= w_warm_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_run_cnt  <= w_run_nxt;
         r_to_cnt   <= w_to_nxt;
         r_shift    <= w_shift_nxt;
         r_data     <= w_data_nxt;
         r_en_sim   <= (w_state_nxt == S_WARMUP) || (w_state_nxt == S_COLLECT);
         r_valid    <= (w_state_nxt == S_HOLD);
         r_busy     <= (w_state_nxt != S_IDLE);
         r_fault    <= (w_state_nxt == S_FAULT);
      end
   end

   assign bus.o_en_sim    = r_en_sim;
   assign bus.o_data      = r_data;
   assign bus.o_valid     = r_valid;
   assign bus.o_busy      = r_busy;
   assign bus.o_fault     = r_fault;
   assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Directed bench for trng_seq_ctrl with default parameters (8-bit word, 16-cycle warm-up).
module tb_trng_seq_ctrl;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WARMUP  = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   en_cnt;
  logic saw_valid;

  trng_seq_ctrl_if #(.WIDTH(8)) bus ();

  trng_seq_ctrl #(
    .WIDTH(8), .WARMUP_CYCLES(16), .REP_LIMIT(8), .TIMEOUT(255)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: each starts and ends just after a falling edge
  task automatic req_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    if (bus.o_en_sim) en_cnt++;
  endtask

  task automatic do_warmup(input logic noise);
    for (int i = 0; i < 16; i++) begin
      bus.i_rand_valid = noise;
      bus.i_rand       = 1'b1;
      @(negedge clk);
      if (bus.o_en_sim) en_cnt++;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    bus.i_rand_valid = 1'b0;
  endtask

  // feeds bits[n-1] first, down to bits[0]
  task automatic feed_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.i_rand_valid = 1'b1;
      bus.i_rand       = bits[i];
      @(negedge clk);
      if (bus.o_en_sim) en_cnt++;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    bus.i_rand_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.i_rand_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic accept_word();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    n_cmp++;
    if ({bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_dbg_state} !== {4'b0000, ST_IDLE}) begin
      n_err++;
      $display("FAIL accept: en/valid/busy/fault/state got %b expected %b",
               {bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_dbg_state}, {4'b0000, ST_IDLE});
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_data, bus.o_dbg_state} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_data, bus.o_dbg_state});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_word();
    en_cnt = 0;
    req_start();
    n_cmp++;
    if ({bus.o_en_sim, bus.o_busy, bus.o_dbg_state} !== {2'b11, ST_WARMUP}) begin
      n_err++;
      $display("FAIL start_warmup: got %b expected %b", {bus.o_en_sim, bus.o_busy, bus.o_dbg_state}, {2'b11, ST_WARMUP});
    end
    do_warmup(1'b0);
    n_cmp++;
    if (bus.o_dbg_state !== ST_COLLECT) begin
      n_err++;
      $display("FAIL warmup_length: state got %0d expected %0d", bus.o_dbg_state, ST_COLLECT);
    end
    feed_bits(8'hB2, 8);
    n_cmp++;
    if ({bus.o_data, bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault} !== {8'hB2, 4'b0110}) begin
      n_err++;
      $display("FAIL basic_word: data/en/valid/busy/fault got %h expected %h",
               {bus.o_data, bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault}, {8'hB2, 4'b0110});
    end
    n_cmp++;
    if (en_cnt !== 24) begin
      n_err++;
      $display("FAIL en_sim_cycles: got %0d expected 24", en_cnt);
    end
    accept_word();
  endtask

  task automatic test_warmup_discard();
    req_start();
    do_warmup(1'b1);
    feed_bits(8'h55, 8);
    n_cmp++;
    if ({bus.o_data, bus.o_valid} !== {8'h55, 1'b1}) begin
      n_err++;
      $display("FAIL warmup_discard: data/valid got %h expected %h", {bus.o_data, bus.o_valid}, {8'h55, 1'b1});
    end
    accept_word();
  endtask

  task automatic test_rep_limit();
    // run of 7 stays below the limit
    req_start();
    do_warmup(1'b0);
    feed_bits(8'hFE, 8);
    n_cmp++;
    if ({bus.o_data, bus.o_valid, bus.o_fault} !== {8'hFE, 2'b10}) begin
      n_err++;
      $display("FAIL rep_below_limit: data/valid/fault got %h expected %h", {bus.o_data, bus.o_valid, bus.o_fault}, {8'hFE, 2'b10});
    end
    accept_word();
    // run of 8 faults, even though it is also the last bit
    saw_valid = 1'b0;
    req_start();
    do_warmup(1'b0);
    feed_bits(8'hFF, 8);
    n_cmp++;
    if ({bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_data, bus.o_dbg_state} !== {4'b0011, 8'h00, ST_FAULT}) begin
      n_err++;
      $display("FAIL rep_fault: en/valid/busy/fault/data/state got %h expected %h",
               {bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_data, bus.o_dbg_state}, {4'b0011, 8'h00, ST_FAULT});
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rep_no_valid: o_valid seen %b expected 0", saw_valid);
    end
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.o_en_sim, bus.o_fault, bus.o_dbg_state} !== {2'b01, ST_FAULT}) begin
      n_err++;
      $display("FAIL fault_ignores_start: got %b expected %b", {bus.o_en_sim, bus.o_fault, bus.o_dbg_state}, {2'b01, ST_FAULT});
    end
    bus.i_clr_fault = 1'b1;
    @(negedge clk);
    bus.i_clr_fault = 1'b0;
    n_cmp++;
    if ({bus.o_fault, bus.o_busy, bus.o_dbg_state} !== {2'b00, ST_IDLE}) begin
      n_err++;
      $display("FAIL clr_fault: fault/busy/state got %b expected %b", {bus.o_fault, bus.o_busy, bus.o_dbg_state}, {2'b00, ST_IDLE});
    end
  endtask

  task automatic test_timeout();
    req_start();
    do_warmup(1'b0);
    idle_cycles(254);
    n_cmp++;
    if ({bus.o_fault, bus.o_dbg_state} !== {1'b0, ST_COLLECT}) begin
      n_err++;
      $display("FAIL timeout_254: fault/state got %b expected %b", {bus.o_fault, bus.o_dbg_state}, {1'b0, ST_COLLECT});
    end
    idle_cycles(1);
    n_cmp++;
    if ({bus.o_fault, bus.o_en_sim, bus.o_dbg_state} !== {2'b10, ST_FAULT}) begin
      n_err++;
      $display("FAIL timeout_255: fault/en/state got %b expected %b", {bus.o_fault, bus.o_en_sim, bus.o_dbg_state}, {2'b10, ST_FAULT});
    end
    bus.i_clr_fault = 1'b1;
    @(negedge clk);
    bus.i_clr_fault = 1'b0;
    // 254 idle cycles, then a bit restarts the starvation count
    req_start();
    do_warmup(1'b0);
    idle_cycles(254);
    feed_bits(8'h01, 1);
    idle_cycles(254);
    n_cmp++;
    if (bus.o_fault !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_restart: fault got %b expected 0", bus.o_fault);
    end
    feed_bits(8'h2A, 7);
    n_cmp++;
    if ({bus.o_data, bus.o_valid, bus.o_fault} !== {8'hAA, 2'b10}) begin
      n_err++;
      $display("FAIL timeout_word: data/valid/fault got %h expected %h", {bus.o_data, bus.o_valid, bus.o_fault}, {8'hAA, 2'b10});
    end
    accept_word();
  endtask

  task automatic test_back_to_back();
    req_start();
    do_warmup(1'b0);
    feed_bits(8'hB2, 8);
    bus.i_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_data, bus.o_valid} !== {8'hB2, 1'b1}) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: data/valid got %h expected %h", i, {bus.o_data, bus.o_valid}, {8'hB2, 1'b1});
      end
    end
    bus.i_ready = 1'b1;
    en_cnt = 0;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_start = 1'b0;
    if (bus.o_en_sim) en_cnt++;
    n_cmp++;
    if ({bus.o_valid, bus.o_en_sim, bus.o_busy, bus.o_dbg_state} !== {3'b011, ST_WARMUP}) begin
      n_err++;
      $display("FAIL b2b_restart: valid/en/busy/state got %b expected %b",
               {bus.o_valid, bus.o_en_sim, bus.o_busy, bus.o_dbg_state}, {3'b011, ST_WARMUP});
    end
    do_warmup(1'b0);
    feed_bits(8'h3C, 8);
    n_cmp++;
    if ({bus.o_data, bus.o_valid, en_cnt} !== {8'h3C, 1'b1, 32'd24}) begin
      n_err++;
      $display("FAIL b2b_word: data=%h valid=%b en_cycles=%0d expected 3c 1 24", bus.o_data, bus.o_valid, en_cnt);
    end
    accept_word();
  endtask

  task automatic test_reset_mid();
    req_start();
    do_warmup(1'b0);
    feed_bits(8'h1A, 5);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_data, bus.o_dbg_state} !== 15'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0",
               {bus.o_en_sim, bus.o_valid, bus.o_busy, bus.o_fault, bus.o_data, bus.o_dbg_state});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en_cnt = 0;
    req_start();
    do_warmup(1'b0);
    feed_bits(8'h69, 8);
    n_cmp++;
    if ({bus.o_data, bus.o_valid, en_cnt} !== {8'h69, 1'b1, 32'd24}) begin
      n_err++;
      $display("FAIL post_reset_word: data=%h valid=%b en_cycles=%0d expected 69 1 24", bus.o_data, bus.o_valid, en_cnt);
    end
    accept_word();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    en_cnt = 0;
    saw_valid = 1'b0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_rand = 1'b0;
    bus.i_rand_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_clr_fault = 1'b0;
    test_reset();
    test_basic_word();
    test_warmup_discard();
    test_rep_limit();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trng_seq_ctrl.md
Name: trng_seq_ctrl

Overview:
- Request/response sequencer for the ring-oscillator entropy unit and de-bias stage.
- On a request it enables the entropy chain and waits a warm-up period. It then collects WIDTH valid de-biased bits into a word and presents that word on a valid/ready handshake.
- While collecting, it runs a repetition-count health test and a starvation timeout; either failure latches a sticky fault.
- Sits between the entropy/de-bias datapath (sync-clock domain) and the consumer logic.

Parameters:
- WIDTH, 8: output word width in bits (>=2).
- WARMUP_CYCLES, 16: clock cycles of enabled chain before bits are accepted (>=1).
- REP_LIMIT, 8: run length of identical consecutive accepted bits that triggers a fault (>=2).
- TIMEOUT, 255: consecutive COLLECT cycles without i_rand_valid that trigger a fault (>=1).

Ports:
- i_clk, in, 1: clock (the divided sync clock driving the entropy unit).
- i_rst, in, 1: reset, asynchronous and active-high.
- i_start, in, 1: request one random word; level-sampled.
- i_rand, in, 1: de-biased random bit.
- i_rand_valid, in, 1: i_rand qualifier (de-bias valid).
- i_ready, in, 1: consumer accepts o_data.
- i_clr_fault, in, 1: clears a latched fault.
- o_en_sim, out, 1: enable to the entropy chain input.
- o_data, out, WIDTH: collected word.
- o_valid, out, 1: o_data valid.
- o_busy, out, 1: state != IDLE.
- o_fault, out, 1: sticky health/timeout fault.

Behaviour:
- All outputs are registered.
- While i_rst=1 (asynchronous): state=IDLE and all counters 0. o_en_sim=0, o_data=0, o_valid=0, o_busy=0, o_fault=0.
- States: IDLE, WARMUP, COLLECT, HOLD, FAULT.
- IDLE:
  - o_en_sim=0.
  - i_start=1 at edge k -> WARMUP; o_en_sim=1 and o_busy=1 after edge k.
  - Loads the warm counter with WARMUP_CYCLES-1; clears the bit count, run count, timeout count and shift register.
- WARMUP:
  - o_en_sim=1; the warm counter decrements each edge; i_rand_valid is ignored.
  - Warm counter==0 -> COLLECT. WARMUP lasts exactly WARMUP_CYCLES cycles.
- COLLECT, o_en_sim=1, on a cycle with i_rand_valid=1:
  - shift <= {shift[WIDTH-2:0], i_rand}, so the first accepted bit ends in the MSB.
  - Bit count increments; timeout count clears.
  - Repetition test: the first bit of a word sets run=1. Each later bit equal to the previous accepted bit increments run; a differing bit sets run=1.
  - If run would reach REP_LIMIT -> FAULT. Fault takes priority over word completion.
  - If the bit count reaches WIDTH (no fault) -> HOLD; o_data<=shift, o_valid=1, and o_en_sim=0 from the next cycle.
- COLLECT, on a cycle with i_rand_valid=0:
  - Timeout count increments.
  - Reaching TIMEOUT -> FAULT.
- HOLD:
  - o_valid=1; o_data is stable until accepted; o_en_sim=0.
  - i_ready=1 -> IDLE, with o_valid=0 after that edge.
  - i_ready=1 with i_start=1 in the same cycle -> WARMUP directly (back-to-back word).
  - i_start without i_ready is ignored.
- FAULT:
  - o_fault=1, o_en_sim=0, o_valid=0, o_data=0, o_busy=1; i_start is ignored.
  - i_clr_fault=1 -> IDLE with o_fault=0.
  - i_clr_fault in any other state has no effect.
- Simultaneous events: a fault condition wins over completion. i_start in WARMUP, COLLECT or FAULT is ignored.
- Counter widths:
  - bit count: clog2(WIDTH+1).
  - warm counter: clog2(WARMUP_CYCLES+1).
  - timeout and run counters: sized to hold TIMEOUT and REP_LIMIT respectively, with no wrap.
- Reset mid-operation: immediate return to the reset values. A partial word is discarded.
- The run test is per word; history is not carried across words.

Test Plan:
- Defaults; reset, then i_start=1 for 1 cycle. After 16 warm-up cycles, drive valid bits 1,0,1,1,0,0,1,0 on consecutive cycles -> o_en_sim high for 24 cycles, then o_data=8'hB2, o_valid=1, o_busy=1.
- During WARMUP drive i_rand_valid=1 with i_rand=1 every cycle, then bits 0,1,0,1,0,1,0,1 -> o_data=8'h55; warm-up bits are discarded.
- In COLLECT feed eight consecutive 1s -> o_fault=1 the cycle after the 8th bit, o_en_sim=0, o_valid never asserts. i_start is then ignored. i_clr_fault=1 -> IDLE, o_fault=0, o_busy=0.
- In COLLECT hold i_rand_valid=0 for 255 cycles -> o_fault=1 after the 255th cycle. With 254 idle cycles followed by a valid bit -> no fault.
- Word ready, i_ready=0 for 10 cycles -> o_data/o_valid stable. Then i_ready=1 with i_start=1 in the same cycle -> next cycle o_valid=0, o_en_sim=1, state WARMUP.
- Assert i_rst mid-COLLECT after 5 bits -> all outputs 0 immediately (asynchronously, before the next clock edge). After release plus i_start -> a full new 16+8 cycle sequence.
